// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the two-input AXI-Stream packet arbiter.
package axis_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_t;

   localparam int CNT_W = 16;

endpackage

// File: rtl/axis_pkt_cnt.sv
// Wrapping packet counter: one-cycle update on inc, wraps all-ones to zero.
module axis_pkt_cnt
   import axis_arb_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (inc) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Round-robin packet arbiter merging two AXI-Stream inputs; zero-latency data mux,
// grant held for a whole packet, one IDLE bubble between packets, m_tready mirrored to the granted input.
module axis_pkt_arbiter
   import axis_arb_pkg::*;
#(
   parameter int DW = 256
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              enable,
   input  logic [DW-1:0]     s0_tdata,
   input  logic [DW/8-1:0]   s0_tkeep,
   input  logic              s0_tlast,
   input  logic              s0_tvalid,
   output logic              s0_tready,
   input  logic [DW-1:0]     s1_tdata,
   input  logic [DW/8-1:0]   s1_tkeep,
   input  logic              s1_tlast,
   input  logic              s1_tvalid,
   output logic              s1_tready,
   output logic [DW-1:0]     m_tdata,
   output logic [DW/8-1:0]   m_tkeep,
   output logic              m_tlast,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              busy,
   output logic              grant_id,
   output logic [CNT_W-1:0]  pkt_count0,
   output logic [CNT_W-1:0]  pkt_count1
);

   arb_state_t state, next_state;
   logic       last_grant, next_grant;
   logic       eop0, eop1;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         state      <= next_state;
         last_grant <= next_grant;
      end
   end

   always_comb begin
      next_state = state;
      next_grant = last_grant;
      m_tdata    = '0;
      m_tkeep    = '0;
      m_tlast    = 1'b0;
      m_tvalid   = 1'b0;
      s0_tready  = 1'b0;
      s1_tready  = 1'b0;
      case (state)
         IDLE: begin
            // On a tie, the input that did not win last time gets the grant.
            if (enable) begin
               if (s0_tvalid && (!s1_tvalid || last_grant)) begin
                  next_state = GRANT0;
                  next_grant = 1'b0;
               end else if (s1_tvalid) begin
                  next_state = GRANT1;
                  next_grant = 1'b1;
               end
            end
         end
         GRANT0: begin
            m_tdata   = s0_tdata;
            m_tkeep   = s0_tkeep;
            m_tlast   = s0_tlast;
            m_tvalid  = s0_tvalid;
            s0_tready = m_tready;
            if (eop0) begin
               next_state = IDLE;
            end
         end
         GRANT1: begin
            m_tdata   = s1_tdata;
            m_tkeep   = s1_tkeep;
            m_tlast   = s1_tlast;
            m_tvalid  = s1_tvalid;
            s1_tready = m_tready;
            if (eop1) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // End of packet: last beat accepted downstream while that input holds the grant.
   assign eop0 = (state == GRANT0) && s0_tvalid && m_tready && s0_tlast;
   assign eop1 = (state == GRANT1) && s1_tvalid && m_tready && s1_tlast;

   assign busy     = (state != IDLE);
   assign grant_id = last_grant;

   axis_pkt_cnt #(.W(CNT_W)) u_cnt0 (
      .clk    (clk),
      .resetn (resetn),
      .inc    (eop0),
      .count  (pkt_count0)
   );

   axis_pkt_cnt #(.W(CNT_W)) u_cnt1 (
      .clk    (clk),
      .resetn (resetn),
      .inc    (eop1),
      .count  (pkt_count1)
   );

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter: cycle table plus hand-written multi-cycle sequences.
module tb_axis_pkt_arbiter;
   import axis_arb_pkg::*;

   localparam int DW = 256;
   localparam int KW = DW / 8;

   logic              clk = 1'b0;
   logic              resetn;
   logic              enable;
   logic [DW-1:0]     s0_tdata, s1_tdata, m_tdata;
   logic [KW-1:0]     s0_tkeep, s1_tkeep, m_tkeep;
   logic              s0_tlast, s1_tlast, m_tlast;
   logic              s0_tvalid, s1_tvalid, m_tvalid;
   logic              s0_tready, s1_tready, m_tready;
   logic              busy, grant_id;
   logic [CNT_W-1:0]  pkt_count0, pkt_count1;
   logic              cnt_inc;
   logic [CNT_W-1:0]  cnt_val;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   axis_pkt_arbiter #(.DW(DW)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .enable     (enable),
      .s0_tdata   (s0_tdata),
      .s0_tkeep   (s0_tkeep),
      .s0_tlast   (s0_tlast),
      .s0_tvalid  (s0_tvalid),
      .s0_tready  (s0_tready),
      .s1_tdata   (s1_tdata),
      .s1_tkeep   (s1_tkeep),
      .s1_tlast   (s1_tlast),
      .s1_tvalid  (s1_tvalid),
      .s1_tready  (s1_tready),
      .m_tdata    (m_tdata),
      .m_tkeep    (m_tkeep),
      .m_tlast    (m_tlast),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .busy       (busy),
      .grant_id   (grant_id),
      .pkt_count0 (pkt_count0),
      .pkt_count1 (pkt_count1)
   );

   // Standalone counter instance so the 16-bit wrap can be reached in a bounded run.
   axis_pkt_cnt #(.W(CNT_W)) u_wrap_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc    (cnt_inc),
      .count  (cnt_val)
   );

   typedef struct {
      logic en, s0v, s0l, s1v, s1l, mr;
      logic mv, ml, s0r, s1r, bsy, gid;
      int   src;
      int   c0, c1;
   } vec_t;

   vec_t tbl[15];

   function automatic vec_t mk(input logic en, s0v, s0l, s1v, s1l, mr,
                               input logic mv, ml, s0r, s1r, bsy, gid,
                               input int src, c0, c1);
      vec_t v;
      v.en = en;  v.s0v = s0v; v.s0l = s0l; v.s1v = s1v; v.s1l = s1l; v.mr = mr;
      v.mv = mv;  v.ml = ml;   v.s0r = s0r; v.s1r = s1r; v.bsy = bsy; v.gid = gid;
      v.src = src; v.c0 = c0;  v.c1 = c1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn    = 1'b0;
      enable    = 1'b0;
      s0_tvalid = 1'b0; s0_tlast = 1'b0;
      s1_tvalid = 1'b0; s1_tlast = 1'b0;
      m_tready  = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   initial begin
      logic [DW-1:0] exp_dat;
      logic [KW-1:0] exp_keep;
      int            exp_st[13];
      logic          b0, b1, acc0, acc1;
      int            beats;

      cnt_inc  = 1'b0;
      s0_tdata = '0; s1_tdata = '0;
      s0_tkeep = '0; s1_tkeep = '0;

      //          en s0v s0l s1v s1l mr | mv ml s0r s1r bsy gid | src c0 c1
      tbl[0]  = mk(0, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 1,   0, 0, 0);
      tbl[1]  = mk(1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 1,   0, 0, 0);
      tbl[2]  = mk(1, 1, 0, 0, 0, 1,   1, 0, 1, 0, 1, 0,   1, 0, 0);
      tbl[3]  = mk(1, 1, 0, 0, 0, 1,   1, 0, 1, 0, 1, 0,   1, 0, 0);
      tbl[4]  = mk(1, 1, 1, 0, 0, 1,   1, 1, 1, 0, 1, 0,   1, 0, 0);
      tbl[5]  = mk(1, 1, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0,   0, 1, 0);
      tbl[6]  = mk(1, 1, 0, 1, 0, 0,   1, 0, 0, 0, 1, 1,   2, 1, 0);
      tbl[7]  = mk(1, 1, 0, 1, 0, 1,   1, 0, 0, 1, 1, 1,   2, 1, 0);
      tbl[8]  = mk(1, 1, 0, 0, 0, 1,   0, 0, 0, 1, 1, 1,   2, 1, 0);
      tbl[9]  = mk(0, 1, 0, 1, 1, 0,   1, 1, 0, 0, 1, 1,   2, 1, 0);
      tbl[10] = mk(0, 1, 0, 1, 1, 1,   1, 1, 0, 1, 1, 1,   2, 1, 0);
      tbl[11] = mk(0, 1, 0, 1, 0, 1,   0, 0, 0, 0, 0, 1,   0, 1, 1);
      tbl[12] = mk(1, 1, 0, 1, 0, 1,   0, 0, 0, 0, 0, 1,   0, 1, 1);
      tbl[13] = mk(1, 1, 1, 1, 0, 1,   1, 1, 1, 0, 1, 0,   1, 1, 1);
      tbl[14] = mk(1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0,   0, 2, 1);

      // Reset values observed while reset is asserted.
      resetn = 1'b0;
      enable = 1'b0;
      s0_tvalid = 1'b1; s0_tlast = 1'b0;
      s1_tvalid = 1'b1; s1_tlast = 1'b0;
      m_tready = 1'b1;
      @(negedge clk);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant_id", grant_id, 1);
      chk("rst_s0_tready", s0_tready, 0);
      chk("rst_s1_tready", s1_tready, 0);
      chk("rst_count0", pkt_count0, 0);
      chk("rst_count1", pkt_count1, 0);

      // Cycle-by-cycle table: 3-beat s0 packet, s1 packet with stalls/valid drop, tie break.
      do_reset();
      for (int i = 0; i < 15; i++) begin
         enable    = tbl[i].en;
         s0_tvalid = tbl[i].s0v; s0_tlast = tbl[i].s0l;
         s1_tvalid = tbl[i].s1v; s1_tlast = tbl[i].s1l;
         m_tready  = tbl[i].mr;
         s0_tdata  = {8{32'hA000_0000 | 32'(i)}};
         s1_tdata  = {8{32'hB000_0000 | 32'(i)}};
         s0_tkeep  = 32'hFFFF_FF00 | 32'(i);
         s1_tkeep  = 32'h00FF_0000 | 32'(i);
         case (tbl[i].src)
            1:       begin exp_dat = s0_tdata; exp_keep = s0_tkeep; end
            2:       begin exp_dat = s1_tdata; exp_keep = s1_tkeep; end
            default: begin exp_dat = '0;       exp_keep = '0;       end
         endcase
         @(negedge clk);
         chk($sformatf("v%0d_m_tvalid", i), m_tvalid, tbl[i].mv);
         chk($sformatf("v%0d_m_tlast", i), m_tlast, tbl[i].ml);
         chk($sformatf("v%0d_s0_tready", i), s0_tready, tbl[i].s0r);
         chk($sformatf("v%0d_s1_tready", i), s1_tready, tbl[i].s1r);
         chk($sformatf("v%0d_busy", i), busy, tbl[i].bsy);
         chk($sformatf("v%0d_grant_id", i), grant_id, tbl[i].gid);
         chk($sformatf("v%0d_m_tdata", i), m_tdata, exp_dat);
         chk($sformatf("v%0d_m_tkeep", i), m_tkeep, exp_keep);
         chk($sformatf("v%0d_count0", i), pkt_count0, tbl[i].c0);
         chk($sformatf("v%0d_count1", i), pkt_count1, tbl[i].c1);
         next_cyc();
      end

      // Both inputs always valid, 2-beat packets: 0,1,0,1 with one IDLE bubble each.
      exp_st = '{0, 1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2, 0};
      do_reset();
      enable = 1'b1; m_tready = 1'b1;
      s0_tvalid = 1'b1; s1_tvalid = 1'b1;
      b0 = 1'b0; b1 = 1'b0;
      for (int k = 0; k < 13; k++) begin
         s0_tlast = b0; s1_tlast = b1;
         @(negedge clk);
         chk($sformatf("rr%0d_busy", k), busy, exp_st[k] != 0);
         chk($sformatf("rr%0d_s0_tready", k), s0_tready, exp_st[k] == 1);
         chk($sformatf("rr%0d_s1_tready", k), s1_tready, exp_st[k] == 2);
         acc0 = s0_tready & s0_tvalid;
         acc1 = s1_tready & s1_tvalid;
         next_cyc();
         b0 = b0 ^ acc0;
         b1 = b1 ^ acc1;
      end
      chk("rr_count0", pkt_count0, 2);
      chk("rr_count1", pkt_count1, 2);

      // Enable dropped during beat 2 of a 4-beat packet: packet completes, then IDLE holds.
      do_reset();
      enable = 1'b1; m_tready = 1'b1;
      s0_tvalid = 1'b1; s1_tvalid = 1'b0;
      beats = 0;
      for (int k = 0; k < 20 && beats < 4; k++) begin
         s0_tlast = (beats == 3);
         if (beats >= 1) enable = 1'b0;
         @(negedge clk);
         if (s0_tready && s0_tvalid) beats++;
         next_cyc();
      end
      chk("en_beats_forwarded", beats, 4);
      chk("en_count0", pkt_count0, 1);
      s0_tlast = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("en_hold%0d_busy", k), busy, 0);
         chk($sformatf("en_hold%0d_m_tvalid", k), m_tvalid, 0);
         chk($sformatf("en_hold%0d_s0_tready", k), s0_tready, 0);
         next_cyc();
      end
      enable = 1'b1;
      @(negedge clk);
      chk("en_reenable_idle", busy, 0);
      next_cyc();
      @(negedge clk);
      chk("en_regrant_busy", busy, 1);
      chk("en_regrant_s0_tready", s0_tready, 1);
      next_cyc();

      // Asynchronous reset in the middle of a packet.
      do_reset();
      enable = 1'b1; m_tready = 1'b1;
      s0_tvalid = 1'b1; s0_tlast = 1'b1;
      next_cyc();
      next_cyc();
      s0_tlast = 1'b0;
      next_cyc();
      @(negedge clk);
      chk("mid_pre_m_tvalid", m_tvalid, 1);
      chk("mid_pre_count0", pkt_count0, 1);
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_m_tvalid", m_tvalid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_grant_id", grant_id, 1);
      chk("mid_rst_s0_tready", s0_tready, 0);
      chk("mid_rst_count0", pkt_count0, 0);
      s1_tvalid = 1'b1;
      next_cyc();
      resetn = 1'b1;
      @(negedge clk);
      chk("mid_post_idle", busy, 0);
      next_cyc();
      @(negedge clk);
      chk("mid_post_s0_tready", s0_tready, 1);
      chk("mid_post_s1_tready", s1_tready, 0);
      chk("mid_post_grant_id", grant_id, 0);
      next_cyc();

      // 16-bit wrap: 65535 increments reach 0xFFFF, the next one returns to zero.
      enable = 1'b0; s0_tvalid = 1'b0; s1_tvalid = 1'b0;
      chk("wrap_start", cnt_val, 0);
      cnt_inc = 1'b1;
      repeat (65535) @(posedge clk);
      #1;
      chk("wrap_ffff", cnt_val, 16'hFFFF);
      next_cyc();
      chk("wrap_zero", cnt_val, 16'h0000);
      cnt_inc = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
